// File: rtl/digi_readout_pkg.sv
// digi_readout_pkg: shared tags, word field positions and FSM states for the readout sequencer.
// Contents: TAG_* word tags, *_LSB field offsets within the 32-bit stream word, state_t FSM encoding.
package digi_readout_pkg;
   localparam logic [3:0] TAG_HDR   = 4'hA;
   localparam logic [3:0] TAG_DATA  = 4'hD;
   localparam logic [3:0] TAG_EMPTY = 4'hE;
   localparam int TAG_LSB   = 28;
   localparam int CH_LSB    = 24;
   localparam int SPILL_LSB = 16;
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_READ, S_EMPTY, S_DRAIN} state_t;
endpackage

// File: rtl/readout_skid_fifo.sv
// readout_skid_fifo: 2-entry FIFO driving a valid/ready stream, push and pop allowed together when full.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write side (caller guarantees space);
//        o_data/o_valid/i_ready stream side; o_count current occupancy (0..2).
module readout_skid_fifo #(
   parameter int W = 33
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_q0, r_q1;
   logic [1:0]   r_cnt;
   logic         w_pop;
   assign o_valid = r_cnt != 2'd0;
   assign w_pop   = o_valid & i_ready;
   assign o_data  = r_q0;
   assign o_count = r_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_q0  <= '0;
         r_q1  <= '0;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 2'(i_push) - 2'(w_pop);
         // r_q0 is always the head; r_q1 only ever holds the second entry
         if (w_pop) r_q0 <= (r_cnt == 2'd2) ? r_q1 : i_data;
         else if (i_push && r_cnt == 2'd0) r_q0 <= i_data;
         if (i_push && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop))) r_q1 <= i_data;
      end
endmodule

// File: rtl/digi_readout_seq.sv
// digi_readout_seq: on end-of-spill, reads every flagged digitizer channel and streams framed 32-bit words.
// Ports: CLK clock, RST async active-low reset; EOS/ch_ready/howmany start a spill;
//        DIN sample bus (valid 1 cycle after rd_request), rd_request/rd_ch_sel digitizer read side;
//        m_tdata/m_tvalid/m_tready/m_tlast output stream; busy readout active; missed_eos EOS while busy.
module digi_readout_seq
   import digi_readout_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int WIDTH = 12,
   parameter int CHAN  = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EOS,
   input  logic [CHAN-1:0]          ch_ready,
   input  logic [SIZE-1:0]          howmany,
   input  logic [WIDTH-1:0]         DIN,
   output logic                     rd_request,
   output logic [$clog2(CHAN)-1:0]  rd_ch_sel,
   output logic [31:0]              m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic                     busy,
   output logic                     missed_eos
);
   localparam int CW = $clog2(CHAN);
   state_t          r_state, w_next;
   logic [CHAN-1:0] r_mask, w_mask_clr;
   logic [SIZE-1:0] r_cnt, r_rem;
   logic [7:0]      r_spill;
   logic [CW-1:0]   r_ch, w_low;
   logic            r_any, r_inflight, r_inf_last, r_missed;
   logic            w_found, w_push, w_rd, w_rd_ok, w_free, w_pop;
   logic [32:0]     w_word, w_hdr, w_data, w_empty;
   logic [1:0]      w_count;
   readout_skid_fifo #(.W(33)) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_data  (w_word),
      .o_data  ({m_tlast, m_tdata}),
      .o_valid (m_tvalid),
      .i_ready (m_tready),
      .o_count (w_count)
   );
   assign w_pop      = m_tvalid & m_tready;
   assign w_free     = (w_count != 2'd2) || w_pop;
   // occupancy after this cycle's pop plus the sample landing next cycle must leave room for one more
   assign w_rd_ok    = 3'(w_count) + 3'(r_inflight) < 3'd2 + 3'(w_pop);
   assign w_mask_clr = r_mask & ~(CHAN'(1) << r_ch);
   assign rd_request = w_rd;
   assign rd_ch_sel  = r_ch;
   assign busy       = r_state != S_IDLE;
   assign missed_eos = r_missed;
   // served bits are cleared, so the lowest remaining bit is the next channel in ascending order
   always_comb begin
      w_found = 1'b0;
      w_low   = '0;
      for (int i = CHAN - 1; i >= 0; i--)
         if (r_mask[i]) begin
            w_found = 1'b1;
            w_low   = CW'(i);
         end
   end
   always_comb begin
      w_hdr                    = '0;
      w_hdr[32]                = (r_cnt == '0) && (w_mask_clr == '0);
      w_hdr[TAG_LSB+:4]        = TAG_HDR;
      w_hdr[CH_LSB+:4]         = 4'(r_ch);
      w_hdr[SPILL_LSB+:8]      = r_spill;
      w_hdr[SIZE-1:0]          = r_cnt;
      w_data                   = '0;
      w_data[32]               = r_inf_last;
      w_data[TAG_LSB+:4]       = TAG_DATA;
      w_data[CH_LSB+:4]        = 4'(r_ch);
      w_data[WIDTH-1:0]        = DIN;
      w_empty                  = '0;
      w_empty[32]              = 1'b1;
      w_empty[TAG_LSB+:4]      = TAG_EMPTY;
      w_empty[SPILL_LSB+:8]    = r_spill;
   end
   always_comb begin
      w_next = r_state;
      w_push = r_inflight;
      w_word = w_data;
      w_rd   = 1'b0;
      case (r_state)
         S_IDLE:  if (EOS) w_next = S_SCAN;
         S_SCAN:  w_next = w_found ? S_HDR : r_any ? S_DRAIN : S_EMPTY;
         S_HDR:
            if (w_free) begin
               w_push = 1'b1;
               w_word = w_hdr;
               w_next = (r_cnt != '0) ? S_READ : S_SCAN;
            end
         S_READ: begin
            w_rd = w_rd_ok;
            if (w_rd_ok && r_rem == SIZE'(1)) w_next = S_SCAN;
         end
         S_EMPTY:
            if (w_free) begin
               w_push = 1'b1;
               w_word = w_empty;
               w_next = S_DRAIN;
            end
         S_DRAIN: if (w_count == 2'd0 && !r_inflight) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         r_state    <= S_IDLE;
         r_mask     <= '0;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_spill    <= '0;
         r_ch       <= '0;
         r_any      <= 1'b0;
         r_inflight <= 1'b0;
         r_inf_last <= 1'b0;
         r_missed   <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_missed   <= EOS && (r_state != S_IDLE);
         r_inflight <= w_rd;
         r_inf_last <= (r_rem == SIZE'(1)) && (r_mask == '0);
         if (r_state == S_IDLE && EOS) begin
            r_mask  <= ch_ready;
            r_cnt   <= howmany;
            r_any   <= |ch_ready;
            r_spill <= r_spill + 8'd1;
         end
         if (r_state == S_SCAN && w_found) r_ch <= w_low;
         if (r_state == S_HDR && w_free) begin
            r_mask <= w_mask_clr;
            r_rem  <= r_cnt;
         end
         if (w_rd) r_rem <= r_rem - SIZE'(1);
      end
endmodule

// File: tb/tb_digi_readout_seq.sv
// tb_digi_readout_seq: directed scenarios for the readout sequencer with a digitizer and stream-sink model.
module tb_digi_readout_seq;
   logic        CLK = 1'b0, RST = 1'b0, EOS = 1'b0;
   logic [7:0]  ch_ready = '0, howmany = '0;
   logic [11:0] DIN = '0;
   logic        rd_request, m_tvalid, m_tlast, busy, missed_eos;
   logic        m_tready = 1'b1;
   logic [2:0]  rd_ch_sel;
   logic [31:0] m_tdata;
   int          n_cmp = 0, n_bad = 0;
   int          ready_mode = 0;
   logic [31:0] q_data[$];
   logic        q_last[$];
   int          rd_pulses = 0, stall_err = 0, missed_cnt = 0;
   logic        prev_stall = 1'b0, pend = 1'b0;
   logic [33:0] prev_word = '0;
   logic [2:0]  pend_ch = '0;
   logic [3:0]  last_ch = 4'hF;
   int          idx = 0;
   digi_readout_seq #(.SIZE(8), .WIDTH(12), .CHAN(8)) dut (
      .CLK(CLK), .RST(RST), .EOS(EOS), .ch_ready(ch_ready), .howmany(howmany), .DIN(DIN),
      .rd_request(rd_request), .rd_ch_sel(rd_ch_sel), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .missed_eos(missed_eos)
   );
   always #5 CLK = ~CLK;
   always @(negedge CLK) begin
      if (!RST) begin
         prev_stall = 1'b0;
         pend = 1'b0;
      end else begin
         if (prev_stall && {m_tvalid, m_tlast, m_tdata} !== prev_word) stall_err++;
         prev_stall = m_tvalid && !m_tready;
         prev_word  = {m_tvalid, m_tlast, m_tdata};
         if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
         end
         if (missed_eos) missed_cnt++;
         pend = rd_request;
         if (rd_request) begin
            rd_pulses++;
            pend_ch = rd_ch_sel;
         end
      end
   end
   always @(posedge CLK) begin
      #1;
      m_tready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
      if (pend) begin
         if ({1'b0, pend_ch} != last_ch) idx = 0;
         DIN = 12'(int'(pend_ch) * 16 + idx);
         idx++;
         last_ch = {1'b0, pend_ch};
      end
   end
   task automatic clear_log();
      q_data.delete();
      q_last.delete();
      rd_pulses = 0;
      stall_err = 0;
      missed_cnt = 0;
      last_ch = 4'hF;
   endtask
   task automatic apply_reset();
      RST = 1'b0;
      EOS = 1'b0;
      ready_mode = 0;
      repeat (2) @(posedge CLK);
      clear_log();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask
   task automatic run_spill(input logic [7:0] mask, input logic [7:0] n, input int limit, output bit to);
      @(posedge CLK);
      #1;
      EOS = 1'b1;
      ch_ready = mask;
      howmany = n;
      @(posedge CLK);
      #1;
      EOS = 1'b0;
      to = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
   endtask
   task automatic test_reset();
      RST = 1'b0;
      #1;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata, rd_request, rd_ch_sel, busy, missed_eos} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b last=%b data=%h rd=%b sel=%0d busy=%b missed=%b, want all 0",
                  m_tvalid, m_tlast, m_tdata, rd_request, rd_ch_sel, busy, missed_eos);
      end
      apply_reset();
      n_cmp++;
      if ({m_tvalid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_release: got valid=%b busy=%b, want 0 0", m_tvalid, busy);
      end
   endtask
   task automatic test_two_channels();
      logic [31:0] exp[8];
      bit to;
      exp = '{32'hA0010003, 32'hD0000000, 32'hD0000001, 32'hD0000002,
              32'hA2010003, 32'hD2000020, 32'hD2000021, 32'hD2000022};
      apply_reset();
      @(posedge CLK);
      #1;
      EOS = 1'b1;
      ch_ready = 8'b0000_0101;
      howmany = 8'd3;
      @(posedge CLK);
      #1;
      EOS = 1'b0;
      @(posedge CLK);
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL latency_early: got valid=%b busy=%b, want 0 1", m_tvalid, busy);
      end
      @(posedge CLK);
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'hA0010003) begin
         n_bad++;
         $display("FAIL latency_first_hdr: got valid=%b data=%h, want 1 a0010003", m_tvalid, m_tdata);
      end
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      n_cmp++;
      if (to !== 1'b0) begin
         n_bad++;
         $display("FAIL two_ch_timeout: busy still %b, want 0", busy);
      end
      n_cmp++;
      if (q_data.size() !== 8) begin
         n_bad++;
         $display("FAIL two_ch_count: got %0d words, want 8", q_data.size());
      end
      for (int i = 0; i < 8 && i < q_data.size(); i++) begin
         n_cmp++;
         if (q_data[i] !== exp[i] || q_last[i] !== (i == 7)) begin
            n_bad++;
            $display("FAIL two_ch_word%0d: got %h last=%b, want %h last=%b", i, q_data[i], q_last[i], exp[i], i == 7);
         end
      end
      n_cmp++;
      if (rd_pulses !== 6) begin
         n_bad++;
         $display("FAIL two_ch_reads: got %0d rd_request, want 6", rd_pulses);
      end
   endtask
   task automatic test_empty_spill();
      bit to;
      apply_reset();
      run_spill(8'h00, 8'd3, 100, to);
      n_cmp++;
      if (to !== 1'b0 || q_data.size() !== 1) begin
         n_bad++;
         $display("FAIL empty_count: got timeout=%b words=%0d, want 0 1", to, q_data.size());
      end else begin
         n_cmp++;
         if (q_data[0] !== 32'hE0010000 || q_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_word: got %h last=%b, want e0010000 last=1", q_data[0], q_last[0]);
         end
      end
      n_cmp++;
      if (rd_pulses !== 0) begin
         n_bad++;
         $display("FAIL empty_reads: got %0d, want 0", rd_pulses);
      end
   endtask
   task automatic test_zero_count();
      bit to;
      apply_reset();
      run_spill(8'b1000_0000, 8'd0, 100, to);
      n_cmp++;
      if (to !== 1'b0 || q_data.size() !== 1) begin
         n_bad++;
         $display("FAIL zero_cnt_count: got timeout=%b words=%0d, want 0 1", to, q_data.size());
      end else begin
         n_cmp++;
         if (q_data[0] !== 32'hA7010000 || q_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_cnt_word: got %h last=%b, want a7010000 last=1", q_data[0], q_last[0]);
         end
      end
      n_cmp++;
      if (rd_pulses !== 0) begin
         n_bad++;
         $display("FAIL zero_cnt_reads: got %0d, want 0", rd_pulses);
      end
   endtask
   task automatic test_random_stall();
      bit to;
      int k;
      logic [31:0] e;
      apply_reset();
      ready_mode = 1;
      run_spill(8'hFF, 8'd255, 30000, to);
      ready_mode = 0;
      n_cmp++;
      if (to !== 1'b0 || q_data.size() !== 2048) begin
         n_bad++;
         $display("FAIL stall_count: got timeout=%b words=%0d, want 0 2048", to, q_data.size());
      end
      k = 0;
      for (int c = 0; c < 8; c++)
         for (int j = -1; j < 255; j++) begin
            e = (j < 0) ? {4'hA, 4'(c), 8'h01, 16'h00FF} : {4'hD, 4'(c), 12'h000, 12'(c * 16 + j)};
            if (k < q_data.size()) begin
               n_cmp++;
               if (q_data[k] !== e || q_last[k] !== (k == 2047)) begin
                  n_bad++;
                  $display("FAIL stall_word%0d: got %h last=%b, want %h last=%b", k, q_data[k], q_last[k], e, k == 2047);
               end
            end
            k++;
         end
      n_cmp++;
      if (stall_err !== 0) begin
         n_bad++;
         $display("FAIL stall_stable: got %0d unstable stalled cycles, want 0", stall_err);
      end
      n_cmp++;
      if (rd_pulses !== 2040) begin
         n_bad++;
         $display("FAIL stall_reads: got %0d, want 2040", rd_pulses);
      end
   endtask
   task automatic test_missed_and_wrap();
      bit to;
      apply_reset();
      @(posedge CLK);
      #1;
      EOS = 1'b1;
      ch_ready = 8'h01;
      howmany = 8'd20;
      @(posedge CLK);
      #1;
      EOS = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      EOS = 1'b1;
      ch_ready = 8'hFF;
      @(posedge CLK);
      #1;
      EOS = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      n_cmp++;
      if (to !== 1'b0 || missed_cnt !== 1 || q_data.size() !== 21) begin
         n_bad++;
         $display("FAIL missed_eos: got timeout=%b pulses=%0d words=%0d, want 0 1 21", to, missed_cnt, q_data.size());
      end
      clear_log();
      for (int s = 0; s < 256; s++) begin
         run_spill(8'h00, 8'd0, 50, to);
         if (to) break;
      end
      n_cmp++;
      if (q_data.size() !== 256) begin
         n_bad++;
         $display("FAIL wrap_count: got %0d words, want 256", q_data.size());
      end else begin
         n_cmp++;
         if (q_data[0] !== 32'hE0020000) begin
            n_bad++;
            $display("FAIL wrap_after_missed: got %h, want e0020000", q_data[0]);
         end
         n_cmp++;
         if (q_data[253] !== 32'hE0FF0000 || q_data[254] !== 32'hE0000000 || q_data[255] !== 32'hE0010000) begin
            n_bad++;
            $display("FAIL wrap_ff_00: got %h %h %h, want e0ff0000 e0000000 e0010000", q_data[253], q_data[254], q_data[255]);
         end
      end
   endtask
   task automatic test_reset_mid_read();
      bit to;
      bit hit;
      apply_reset();
      ready_mode = 2;
      @(posedge CLK);
      #1;
      EOS = 1'b1;
      ch_ready = 8'hFF;
      howmany = 8'd10;
      @(posedge CLK);
      #1;
      EOS = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (m_tvalid && busy && dut.r_state == digi_readout_pkg::S_READ) begin
            hit = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (hit !== 1'b1) begin
         n_bad++;
         $display("FAIL midread_reach: got valid=%b busy=%b, want READ with valid=1", m_tvalid, busy);
      end
      #2;
      RST = 1'b0;
      #1;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata, rd_request, rd_ch_sel, busy, missed_eos} !== '0) begin
         n_bad++;
         $display("FAIL midread_async: got valid=%b last=%b data=%h rd=%b sel=%0d busy=%b, want all 0",
                  m_tvalid, m_tlast, m_tdata, rd_request, rd_ch_sel, busy);
      end
      ready_mode = 0;
      repeat (2) @(posedge CLK);
      clear_log();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      run_spill(8'h02, 8'd1, 100, to);
      n_cmp++;
      if (to !== 1'b0 || q_data.size() !== 2) begin
         n_bad++;
         $display("FAIL post_reset_count: got timeout=%b words=%0d, want 0 2", to, q_data.size());
      end else begin
         n_cmp++;
         if (q_data[0] !== 32'hA1010001 || q_data[1] !== 32'hD1000010 || q_last[1] !== 1'b1 || q_last[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_words: got %h/%b %h/%b, want a1010001/0 d1000010/1", q_data[0], q_last[0], q_data[1], q_last[1]);
         end
      end
   endtask
   initial begin
      test_reset();
      test_two_channels();
      test_empty_spill();
      test_zero_count();
      test_random_stall();
      test_missed_and_wrap();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/digi_readout_seq.md
Name: digi_readout_seq

Overview:
- Readout sequencer directly downstream of the multi-channel digitizer.
- On end-of-spill, walks every channel flagged as holding data in ascending order. For each channel it drives the channel select and one-cycle read strobes, and collects `howmany` samples per channel from the shared 12-bit data bus.
- Frames the samples with a per-channel header and streams 32-bit words to the ZYNQ over a valid/ready stream interface with a last marker per spill.

Parameters:
- SIZE, 8, width of the sample count (`howmany`).
- WIDTH, 12, sample width on DIN; legal range 1..24.
- CHAN, 8, number of channels; legal range 2..16.

Ports:
- CLK, input, 1, system clock; all logic is on this single clock.
- RST, input, 1, asynchronous active-low reset.
- EOS, input, 1, end-of-spill pulse; starts one readout.
- ch_ready, input, CHAN, per-channel "captured data" flags; sampled at EOS.
- howmany, input, SIZE, samples per channel; sampled at EOS.
- DIN, input, WIDTH, sample bus from the digitizer; valid exactly 1 cycle after rd_request.
- rd_request, output, 1, one-cycle read strobe to the selected channel.
- rd_ch_sel, output, $clog2(CHAN), channel select.
- m_tdata, output, 32, stream data.
- m_tvalid, output, 1, stream valid.
- m_tready, input, 1, stream ready.
- m_tlast, output, 1, last word of the spill.
- busy, output, 1, readout in progress.
- missed_eos, output, 1, one-cycle pulse when EOS arrives while busy.

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, FSM to IDLE, FIFO emptied, spill counter 0. Any in-flight read is abandoned; m_tvalid drops immediately.
- Accepted EOS (IDLE, EOS=1):
  - Latch mask=ch_ready and cnt=howmany.
  - Increment the 8-bit spill counter; it wraps 255 to 0. The first spill is numbered 1.
  - Set busy the next cycle.
- EOS while busy: ignored; missed_eos pulses for 1 cycle. EOS together with reset is ignored.
- FSM states:
  - IDLE -> SCAN on accepted EOS.
  - SCAN: find the lowest set mask bit at or above the current channel.
    - Found: drive rd_ch_sel and go to HDR.
    - None found and no channel was ever set: go to EMPTY.
    - None found otherwise: go to DRAIN.
  - HDR: push the header word when a FIFO slot is free, clear that mask bit, then go to READ (cnt>0) or SCAN (cnt=0).
  - READ: issue rd_request whenever (FIFO occupancy + reads in flight) < 2. After cnt strobes, go to SCAN.
  - EMPTY: push the empty word, then go to DRAIN.
  - DRAIN: when the FIFO is empty and the last word has been accepted, go to IDLE and drop busy.
- Read timing:
  - DIN is captured into the FIFO the cycle after each rd_request.
  - rd_ch_sel stays stable from HDR until 1 cycle after the channel's final rd_request.
  - rd_request is never asserted on two channels without an intervening change of rd_ch_sel.
- Word formats (unused bits are 0):
  - Header: [31:28]=4'hA, [27:24]=channel, [23:16]=spill number, [SIZE-1:0]=cnt.
  - Data: [31:28]=4'hD, [27:24]=channel, [WIDTH-1:0]=DIN.
  - Empty spill: [31:28]=4'hE, [23:16]=spill number.
- m_tlast is 1 on the final word of the spill only. That is the last data word of the highest flagged channel, or its header if cnt=0, or the empty word.
- Stream rules:
  - m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never drops without a handshake, except on reset.
  - Stalling m_tready stalls reads; no sample is ever dropped.
  - Full throughput is 1 word/cycle with m_tready held high.
- Latency: the first header is valid 2 cycles after the EOS edge, given m_tready=1.

Decomposition:
- Package digi_readout_pkg holds:
  - tag constants TAG_HDR=4'hA, TAG_DATA=4'hD, TAG_EMPTY=4'hE;
  - the FSM state enum;
  - header/data field positions.
- One sub-module, readout_skid_fifo: 2-entry, 33-bit (data + last) FIFO providing m_tvalid/m_tready, count, and synchronous push/pop with simultaneous push+pop when full.

Test Plan:
- ch_ready=8'b0000_0101, howmany=3, m_tready=1, DIN=channel*16+read index -> words A0_01_003, D0_000000, D0_000001, D0_000002, A2_01_003, D2_000020, D2_000021, D2_000022; tlast on the last word; exactly 6 rd_request pulses.
- ch_ready=0 at EOS -> single word E0_01_0000 with tlast; zero rd_request pulses.
- howmany=0, ch_ready=8'b1000_0000 -> single header A7_01_000 with tlast; no reads.
- m_tready random 30% duty, ch_ready=8'hFF, howmany=255 -> 8×256 words in order; no drop or duplicate; m_tdata stable during stalls.
- Second EOS mid-readout -> missed_eos pulses once; the spill counter is unchanged. Follow with 256 accepted spills -> the spill field wraps from FF to 00.
- Reset asserted mid-READ with m_tvalid=1 -> all outputs 0 asynchronously. A fresh EOS after release starts a clean readout with spill number 01.
